div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 24 ++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
package div_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_STEPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Two's-complement negate when neg is set, pass through otherwise.
  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] value,
                                                input logic             neg);
    cond_neg = neg ? (~value + {{(DIV_W-1){1'b0}}, 1'b1}) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   rem_in,
  input  logic             dvnd_bit,
  input  logic [DIV_W-1:0] dvsr,
  output logic [DIV_W:0]   rem_out,
  output logic             q_bit
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // A set top bit means the true shifted value exceeds 2^17, so the subtract
  // always succeeds and the wrapped 17-bit difference is still exact.
  always_comb begin
    shifted = {rem_in[DIV_W-1:0], dvnd_bit};
    trial   = shifted - {1'b0, dvsr};
    q_bit   = rem_in[DIV_W] | (shifted >= {1'b0, dvsr});
    rem_out = q_bit ? trial : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// Sequential 16-bit restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to add the div_signed input and two's-complement mode.
module div_unit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             div_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_zero
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);
  localparam logic [4:0] FIX_STEP  = 5'(DIV_STEPS);

  div_state_e       state;
  logic [4:0]       step_cnt;
  logic [DIV_W:0]   rem;
  logic [DIV_W-1:0] q_work;
  logic [DIV_W-1:0] dvsr;

  logic [DIV_W:0]   rem_next;
  logic             q_bit;
  logic [DIV_W-1:0] q_next;

  logic [DIV_W-1:0] dvnd_mag;
  logic [DIV_W-1:0] dvsr_mag;
  logic             use_fixup;

`ifdef DIV_SIGNED_EN
  logic signed_op;
  logic neg_q;
  logic neg_r;

  always_comb begin
    dvnd_mag = cond_neg(dividend, div_signed & dividend[DIV_W-1]);
    dvsr_mag = cond_neg(divisor,  div_signed & divisor[DIV_W-1]);
  end

  assign use_fixup = signed_op;
`else
  assign dvnd_mag  = dividend;
  assign dvsr_mag  = divisor;
  assign use_fixup = 1'b0;
`endif

  div_step u_step (
    .rem_in   (rem),
    .dvnd_bit (q_work[DIV_W-1]),
    .dvsr     (dvsr),
    .rem_out  (rem_next),
    .q_bit    (q_bit)
  );

  assign q_next = {q_work[DIV_W-2:0], q_bit};
  assign busy   = (state == RUN);
  assign done   = (state == FIN);

  // q_work starts as the dividend and fills with quotient bits as it shifts out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_cnt  <= '0;
      rem       <= '0;
      q_work    <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      signed_op <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (start) begin
            step_cnt <= '0;
            rem      <= '0;
            q_work   <= dvnd_mag;
            dvsr     <= dvsr_mag;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            signed_op <= div_signed;
            neg_q     <= div_signed & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
            neg_r     <= div_signed & dividend[DIV_W-1];
`endif
            if (divisor == '0) begin
              state     <= FIN;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt <= LAST_STEP) begin
            rem    <= rem_next;
            q_work <= q_next;
          end
          if (step_cnt == LAST_STEP && !use_fixup) begin
            state     <= FIN;
            quotient  <= q_next;
            remainder <= rem_next[DIV_W-1:0];
          end
`ifdef DIV_SIGNED_EN
          // Extra cycle restores signs on the magnitude results.
          if (step_cnt == FIX_STEP) begin
            state     <= FIN;
            quotient  <= cond_neg(q_work, neg_q);
            remainder <= cond_neg(rem[DIV_W-1:0], neg_r);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
`ifdef DIV_SIGNED_EN
  logic        div_signed = 1'b0;
`endif

  bit signed_mode = 1'b0;
  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef DIV_SIGNED_EN
    .div_signed(div_signed),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit sm,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output int lat);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dz = 1'b1; lat = 1;
    end else if (sm) begin
      q = 16'(sa / sb); r = 16'(sa % sb); dz = 1'b0; lat = 18;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = 17;
    end
  endfunction

  task automatic driveStart(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
`ifdef DIV_SIGNED_EN
    div_signed = signed_mode;
`endif
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    driveStart(a, b);
  endtask

  // Waits for done after a start sampled 'elapsed' negedges ago; ends on the done negedge.
  task automatic waitResult(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input int elapsed);
    logic [15:0] eq, er;
    logic edz;
    int elat;
    int lat = 0;
    int busy_cycles = 0;
    bit seen = 1'b0;
    model(a, b, signed_mode, eq, er, edz, elat);
    for (int i = elapsed + 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin seen = 1'b1; lat = i; end
    end
    checkOutput($sformatf("%s.done_seen", tag), 32'(seen), 32'd1);
    if (seen) begin
      checkOutput($sformatf("%s.latency", tag), 32'(lat), 32'(elat));
      checkOutput($sformatf("%s.quotient", tag), 32'(quotient), 32'(eq));
      checkOutput($sformatf("%s.remainder", tag), 32'(remainder), 32'(er));
      checkOutput($sformatf("%s.div_zero", tag), 32'(div_zero), 32'(edz));
      checkOutput($sformatf("%s.busy_cycles", tag), 32'(busy_cycles), 32'(elat - 1 - elapsed));
    end
  endtask

  task automatic runDivision(input string tag, input logic [15:0] a, input logic [15:0] b);
    applyStimulus(a, b);
    waitResult(tag, a, b, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] a, b, hold_q, hold_r;
    int done_count;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.quotient", 32'(quotient), 32'd0);
    checkOutput("reset.remainder", 32'(remainder), 32'd0);
    checkOutput("reset.div_zero", 32'(div_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    runDivision("d100_7", 16'd100, 16'd7);
    hold_q = quotient;
    hold_r = remainder;
    repeat (3) @(negedge clk);
    checkOutput("hold.done_low", 32'(done), 32'd0);
    checkOutput("hold.quotient", 32'(quotient), 32'(hold_q));
    checkOutput("hold.remainder", 32'(remainder), 32'(hold_r));

    runDivision("dffff_1", 16'hFFFF, 16'd1);
    runDivision("d5_9", 16'd5, 16'd9);
    runDivision("d1234_0", 16'd1234, 16'd0);

    // Start during RUN is ignored; start in the FIN cycle is accepted.
    applyStimulus(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    driveStart(16'd50, 16'd5);
    waitResult("ignored", 16'd100, 16'd7, 5);
    driveStart(16'd50, 16'd5);
    waitResult("fin_start", 16'd50, 16'd5, 0);

    // Reset in the middle of a division.
    applyStimulus(16'd100, 16'd7);
    repeat (7) @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset.busy", 32'(busy), 32'd0);
    checkOutput("midreset.done", 32'(done), 32'd0);
    checkOutput("midreset.quotient", 32'(quotient), 32'd0);
    checkOutput("midreset.remainder", 32'(remainder), 32'd0);
    checkOutput("midreset.div_zero", 32'(div_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    done_count = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("midreset.no_done", 32'(done_count), 32'd0);
    runDivision("after_reset", 16'd1000, 16'd33);

    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      runDivision($sformatf("rand%0d", i), a, b);
    end

`ifdef DIV_SIGNED_EN
    signed_mode = 1'b1;
    runDivision("s_m7_2", 16'hFFF9, 16'd2);
    runDivision("s_8000_ffff", 16'h8000, 16'hFFFF);
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      runDivision($sformatf("srand%0d", i), a, b);
    end
    signed_mode = 1'b0;
    runDivision("u_after_signed", 16'hFFF9, 16'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
